// File: rtl/spk_pkg.sv
// ----------------------------------------------------------------------------
// spk_pkg
// Shared definitions for the speaker arbiter: FSM state encoding, note and
// duration widths, the rest-note constant and a small duration helper.
//
// Contents:
//   NOTE_W / DUR_W  - width of a fullNote code and of a duration in ticks
//   NOTE_REST       - note code that keeps the tone generator silent
//   spk_state_t     - SPK_IDLE / SPK_PLAY / SPK_GAP
//   spk_dur_last()  - converts a requested duration into the index of its
//                     final tick (a duration of 0 plays as 1 tick)
// ----------------------------------------------------------------------------
package spk_pkg;

    localparam int NOTE_W = 8;
    localparam int DUR_W  = 8;

    localparam logic [NOTE_W-1:0] NOTE_REST = 8'd0;

    typedef enum logic [1:0] {
        SPK_IDLE = 2'd0,
        SPK_PLAY = 2'd1,
        SPK_GAP  = 2'd2
    } spk_state_t;

    // The duration counter runs 0..D-1, so the latch stores D-1. A zero
    // duration maps to the same value as one tick.
    function automatic logic [DUR_W-1:0] spk_dur_last(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? '0 : dur - DUR_W'(1);
    endfunction

endpackage

// File: rtl/spk_rr_pick.sv
// ----------------------------------------------------------------------------
// spk_rr_pick
// Combinational round-robin picker. Starting just after the previous grantee,
// it searches upward (wrapping) and returns the first requester that is
// asking.
//
// Ports:
//   req    in  NUM_REQ  request vector, one bit per requester
//   last   in  IDX_W    index of the previous grantee
//   valid  out 1        at least one request is pending
//   grant  out IDX_W    chosen requester (meaningful only when valid)
// ----------------------------------------------------------------------------
module spk_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   grant
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [IDX_W-1:0]     offset;
    logic [IDX_W:0]       sum;

    // Rotate the request vector so that bit 0 is the requester right after
    // 'last'; the lowest set bit of the rotated vector is then the winner.
    // The sum last+1+offset stays below 2*NUM_REQ, so one conditional
    // subtraction is enough to wrap it back into range.
    always_comb begin
        doubled = {req, req};
        rotated = NUM_REQ'(doubled >> ({1'b0, last} + 1'b1));
        valid   = |req;
        offset  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                offset = IDX_W'(j);
            end
        end
        sum = {1'b0, last} + {1'b0, offset} + 1'b1;
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end
        grant = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/speaker_arbiter.sv
// ----------------------------------------------------------------------------
// speaker_arbiter
// Shares the single speaker tone generator between several requesters. A
// request is granted round-robin, its note is driven for max(dur,1) ticks,
// then GAP_TICKS silent ticks follow before completion is reported.
//
// Optional feature: define SPK_PREEMPT_EN to make requester 0 urgent; it then
// cuts off any note owned by another requester (the victim gets its done
// pulse in the same cycle as ack[0]).
//
// Parameters:
//   NUM_REQ    number of requesters (2..8)
//   TICK_DIV   clock cycles per duration tick
//   GAP_TICKS  silent ticks after each note (0 = none)
//
// Ports:
//   clk       in  1            clock
//   rst_n     in  1            asynchronous active-low reset
//   req       in  NUM_REQ      level requests, held until ack
//   req_note  in  8*NUM_REQ    note of requester i at [8i+7:8i]
//   req_dur   in  8*NUM_REQ    duration (ticks) of requester i at [8i+7:8i]
//   ack       out NUM_REQ      one-cycle pulse when a request is latched
//   done      out NUM_REQ      one-cycle pulse when a note and its gap end
//   note_out  out 8            note to the tone generator, 0 = silence
//   busy      out 1            high while playing or in the gap
//   owner     out clog2(N)     current or most recent grantee
// ----------------------------------------------------------------------------
module speaker_arbiter
    import spk_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TICK_DIV  = 4194304,
    parameter int GAP_TICKS = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NOTE_W*NUM_REQ-1:0]   req_note,
    input  logic [DUR_W*NUM_REQ-1:0]    req_dur,
    output logic [NUM_REQ-1:0]          ack,
    output logic [NUM_REQ-1:0]          done,
    output logic [NOTE_W-1:0]           note_out,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]  GAP_LAST  = (GAP_TICKS > 0) ? DUR_W'(GAP_TICKS - 1) : '0;

    spk_state_t state;
    spk_state_t state_nxt;

    logic [TICK_W-1:0] tick_cnt;
    logic [DUR_W-1:0]  dur_cnt;
    logic [NOTE_W-1:0] note_lat;
    logic [DUR_W-1:0]  dur_last;
    logic [IDX_W-1:0]  last;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  grant_idx;
    logic              tick_end;
    logic              play_end;
    logic              gap_end;
    logic              preempt;
    logic              start;
    logic              finish;

    spk_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .grant (pick_idx)
    );

    // State register; reset forces IDLE immediately so note_out and busy
    // drop in the same cycle the reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SPK_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. 'start' covers both a normal IDLE grant and an
    // urgent takeover by requester 0; 'finish' marks the edge that returns
    // to IDLE after a completed note, which is when done is raised.
    always_comb begin
        tick_end = (tick_cnt == TICK_LAST);
        play_end = tick_end && (dur_cnt == dur_last);
        gap_end  = tick_end && (dur_cnt == GAP_LAST);
`ifdef SPK_PREEMPT_EN
        preempt  = (state != SPK_IDLE) && (owner != '0) && req[0];
`else
        preempt  = 1'b0;
`endif
        start     = preempt || ((state == SPK_IDLE) && pick_valid);
        grant_idx = preempt ? '0 : pick_idx;
        finish    = 1'b0;
        state_nxt = state;
        unique case (state)
            SPK_IDLE: begin
                if (start) begin
                    state_nxt = SPK_PLAY;
                end
            end
            SPK_PLAY: begin
                if (preempt) begin
                    state_nxt = SPK_PLAY;
                end else if (play_end) begin
                    if (GAP_TICKS == 0) begin
                        finish    = 1'b1;
                        state_nxt = SPK_IDLE;
                    end else begin
                        state_nxt = SPK_GAP;
                    end
                end
            end
            SPK_GAP: begin
                if (preempt) begin
                    state_nxt = SPK_PLAY;
                end else if (gap_end) begin
                    finish    = 1'b1;
                    state_nxt = SPK_IDLE;
                end
            end
            default: state_nxt = SPK_IDLE;
        endcase
    end

    // Latches, counters and the ack/done pulses. Counters restart on every
    // state entry (including a preemptive restart of PLAY), so each phase is
    // timed exactly from its first cycle. done uses the owner before it is
    // overwritten, which is what makes a preempted owner see its done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            dur_cnt  <= '0;
            note_lat <= NOTE_REST;
            dur_last <= '0;
            last     <= IDX_W'(NUM_REQ - 1);
            owner    <= '0;
            ack      <= '0;
            done     <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            if (finish || preempt) begin
                done <= NUM_REQ'(1) << owner;
            end
            if (start) begin
                note_lat <= req_note[{grant_idx, 3'b000} +: NOTE_W];
                dur_last <= spk_dur_last(req_dur[{grant_idx, 3'b000} +: DUR_W]);
                last     <= grant_idx;
                owner    <= grant_idx;
                ack      <= NUM_REQ'(1) << grant_idx;
            end
            if (start || (state_nxt != state)) begin
                tick_cnt <= '0;
                dur_cnt  <= '0;
            end else if (state != SPK_IDLE) begin
                if (tick_end) begin
                    tick_cnt <= '0;
                    dur_cnt  <= dur_cnt + 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    // Outputs decoded from state; the note is only audible in PLAY.
    always_comb begin
        busy     = (state != SPK_IDLE);
        note_out = (state == SPK_PLAY) ? note_lat : NOTE_REST;
    end

endmodule

// File: tb/tb_speaker_arbiter.sv
// ----------------------------------------------------------------------------
// tb_speaker_arbiter
// Self-checking bench for speaker_arbiter with NUM_REQ=4, TICK_DIV=4,
// GAP_TICKS=1. A transaction-level model predicts, for every grant, the ack
// cycle, the done cycle and the note_out/busy timeline from the arithmetic
// rules of the block; expected ack/done events go into a scoreboard queue
// that an independent monitor drains. Directed scenarios run first, then a
// randomized phase. Follows SPK_PREEMPT_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_speaker_arbiter;

    localparam int N    = 4;
    localparam int T    = 4;
    localparam int G    = 1;
    localparam int MAXC = 4096;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_note;
    logic [8*N-1:0] req_dur;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic [7:0]     note_out;
    logic           busy;
    logic [1:0]     owner;

    speaker_arbiter #(
        .NUM_REQ   (N),
        .TICK_DIV  (T),
        .GAP_TICKS (G)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_note (req_note),
        .req_dur  (req_dur),
        .ack      (ack),
        .done     (done),
        .note_out (note_out),
        .busy     (busy),
        .owner    (owner)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] ack;
        logic [N-1:0] done;
        int           owner;
    } evt_t;

    evt_t       sb[$];
    logic [7:0] exp_note [MAXC];
    bit         exp_busy [MAXC];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    bit [N-1:0] pend;
    bit [N-1:0] drop_next;
    int         m_last;
    int         m_owner;
    int         idle_from;

    // Free-running clock and cycle index (cycle n follows the n-th edge).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    function automatic int rr_pick(input bit [N-1:0] p, input int from_last);
        for (int k = 1; k <= N; k++) begin
            if (p[(from_last + k) % N]) return (from_last + k) % N;
        end
        return -1;
    endfunction

    function automatic int rand_note();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 95));
    endfunction

    task automatic applyStimulus(input int i, input int note, input int dur);
        pend[i]              = 1'b1;
        req_note[i*8 +: 8]   = 8'(note);
        req_dur[i*8 +: 8]    = 8'(dur);
    endtask

    // Grant requester g at the edge ending cycle c. A preemptive grant
    // replaces the victim's pending done with a combined done+ack event.
    task automatic do_grant(input int c, input int g, input bit pre);
        evt_t e;
        int   deff;
        int   endc;
        logic [7:0] nt;
        nt   = req_note[g*8 +: 8];
        deff = (req_dur[g*8 +: 8] == 8'd0) ? 1 : int'(req_dur[g*8 +: 8]);
        endc = c + 1 + (deff + G) * T;
        for (int t = c + 1; t <= idle_from && t < MAXC; t++) begin
            exp_note[t] = 8'd0;
            exp_busy[t] = 1'b0;
        end
        e.cyc   = c + 1;
        e.ack   = N'(1) << g;
        e.done  = '0;
        e.owner = g;
        if (pre) begin
            void'(sb.pop_back());
            e.done = N'(1) << m_owner;
        end
        sb.push_back(e);
        e.cyc   = endc;
        e.ack   = '0;
        e.done  = N'(1) << g;
        sb.push_back(e);
        for (int t = c + 1; t < endc && t < MAXC; t++) begin
            exp_busy[t] = 1'b1;
            exp_note[t] = (t <= c + deff * T) ? nt : 8'd0;
        end
        idle_from    = endc;
        m_last       = g;
        m_owner      = g;
        drop_next[g] = 1'b1;
    endtask

    task automatic model_edge(input int c);
        if (c >= idle_from) begin
            if (pend != '0) do_grant(c, rr_pick(pend, m_last), 1'b0);
        end
`ifdef SPK_PREEMPT_EN
        else if (m_owner != 0 && pend[0]) begin
            do_grant(c, 0, 1'b1);
        end
`endif
    endtask

    // One driver cycle: release granted requests, optionally churn random
    // requests and notes, drive req, then predict the coming edge.
    task automatic step(input bit rand_en);
        int c;
        c = cyc;
        for (int i = 0; i < N; i++) begin
            if (drop_next[i]) begin
                drop_next[i] = 1'b0;
                if (!(rand_en && $urandom_range(0, 3) == 0)) pend[i] = 1'b0;
            end else if (rand_en && pend[i] && $urandom_range(0, 39) == 0) begin
                pend[i] = 1'b0;
            end
            if (rand_en && !pend[i] && $urandom_range(0, 7) == 0)
                applyStimulus(i, rand_note(), int'($urandom_range(0, 3)));
            if (rand_en && $urandom_range(0, 15) == 0)
                req_note[i*8 +: 8] = 8'(rand_note());
        end
        req = pend;
        model_edge(c);
    endtask

    task automatic next_cycle(input bit rand_en);
        @(negedge clk);
        #2;
        step(rand_en);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((cyc < idle_from || pend != '0 || drop_next != '0) && n < budget) begin
            next_cycle(1'b0);
            n++;
        end
        checkOutput("drain_idle", int'(cyc < idle_from || pend != '0), 0);
    endtask

    // Monitor: compares the note/busy timeline every cycle and pops the
    // scoreboard whenever the DUT pulses ack or done.
    always @(negedge clk) begin : monitor
        evt_t e;
        if (cyc < MAXC) begin
            checkOutput("note_out", int'(note_out), int'(exp_note[cyc]));
            checkOutput("busy", int'(busy), int'(exp_busy[cyc]));
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checkOutput("missed_event_cycle", -1, e.cyc);
        end
        if ((ack | done) != '0) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_ack_done", int'({ack, done}), 0);
            end else begin
                e = sb.pop_front();
                checkOutput("event_cycle", cyc, e.cyc);
                checkOutput("ack", int'(ack), int'(e.ack));
                checkOutput("done", int'(done), int'(e.done));
                checkOutput("owner", int'(owner), e.owner);
            end
        end
    end

    initial begin
        for (int t = 0; t < MAXC; t++) begin
            exp_note[t] = 8'd0;
            exp_busy[t] = 1'b0;
        end
        rst_n     = 1'b1;
        req       = '0;
        req_note  = '0;
        req_dur   = '0;
        pend      = '0;
        drop_next = '0;
        m_last    = N - 1;
        m_owner   = 0;
        idle_from = 0;
        #1 rst_n = 1'b0;

        repeat (3) @(negedge clk);
        #2;
        checkOutput("reset_ack", int'(ack), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_note_out", int'(note_out), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_owner", int'(owner), 0);
        rst_n = 1'b1;
        step(1'b0);

        $display("[TB] directed: single note on requester 1");
        next_cycle(1'b0);
        applyStimulus(1, 25, 2);
        step(1'b0);
        drain(100);

        $display("[TB] directed: round-robin between 0 and 2, then wrap to 0");
        @(negedge clk); #2;
        applyStimulus(0, 40, 1);
        applyStimulus(2, 50, 3);
        step(1'b0);
        drain(100);
        @(negedge clk); #2;
        applyStimulus(0, 41, 2);
        step(1'b0);
        drain(100);

        $display("[TB] directed: zero duration and rest note");
        @(negedge clk); #2;
        applyStimulus(3, 30, 0);
        step(1'b0);
        drain(100);
        @(negedge clk); #2;
        applyStimulus(2, 0, 1);
        step(1'b0);
        drain(100);

        $display("[TB] directed: requester 0 arriving while 3 plays");
        @(negedge clk); #2;
        applyStimulus(3, 60, 3);
        step(1'b0);
        repeat (3) next_cycle(1'b0);
        @(negedge clk); #2;
        applyStimulus(0, 70, 1);
        req_note[3*8 +: 8] = 8'd99;
        step(1'b0);
        drain(100);

        $display("[TB] directed: reset in the middle of a note");
        @(negedge clk); #2;
        applyStimulus(3, 61, 3);
        step(1'b0);
        repeat (3) next_cycle(1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_note_out", int'(note_out), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_ack", int'(ack), 0);
        checkOutput("midreset_done", int'(done), 0);
        checkOutput("midreset_owner", int'(owner), 0);
        for (int t = cyc + 1; t <= idle_from && t < MAXC; t++) begin
            exp_note[t] = 8'd0;
            exp_busy[t] = 1'b0;
        end
        sb.delete();
        pend      = '0;
        drop_next = '0;
        req       = '0;
        m_last    = N - 1;
        m_owner   = 0;
        idle_from = cyc + 1;
        @(negedge clk); #2;
        rst_n = 1'b1;
        applyStimulus(1, 11, 1);
        applyStimulus(0, 12, 1);
        step(1'b0);
        drain(100);

        $display("[TB] randomized phase");
        repeat (2500) next_cycle(1'b1);
        drain(400);
        repeat (4) next_cycle(1'b0);
        checkOutput("leftover_events", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
